load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: takes a single load/store request from the pipeline MEM stage and computes base + sign-extended 12-bit offset.
- Drives a word-wide, byte-enabled memory port with a req/ack handshake, and returns load data sign- or zero-extended per funct3.
- Misaligned accesses that cross a word boundary are split into two word transactions; illegal encodings are rejected without touching memory.

Parameters:
SPLIT_EN, 1, 1 = split word-crossing accesses into two transactions; 0 = flag them as rsp_error with no memory access
ADDR_W, 32, byte-address width; address arithmetic wraps modulo 2^ADDR_W

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  pipeline request present
req_ready  output  1  unit idle and able to accept
req_write  input  1  1 = store, 0 = load
req_base  input  ADDR_W  base address (rs1)
req_offset  input  12  signed immediate offset
req_funct3  input  3  RV32 size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
req_wdata  input  32  store data, LSB-aligned
rsp_valid  output  1  one-cycle completion pulse
rsp_error  output  1  qualifies rsp_valid: illegal or unsplittable access
rsp_rdata  output  32  extended load data; 0 for stores and errors
mem_req  output  1  memory transaction request
mem_we  output  1  write strobe
mem_addr  output  ADDR_W  word-aligned address, bits [1:0] = 0
mem_be  output  4  byte lane enables
mem_wdata  output  32  lane-positioned write data
mem_ack  input  1  memory accepted/completed the current transaction; may be high in the same cycle as mem_req
mem_rdata  input  32  read word, valid when mem_ack is high

Behaviour:
- Reset (async assert, sync-to-clk release): state IDLE. req_ready=1; rsp_valid, rsp_error, mem_req, mem_we=0; mem_addr, mem_be, mem_wdata, rsp_rdata=0.
- Reset mid-transaction aborts immediately: mem_req drops asynchronously and no response is issued.
- States:
  - IDLE: req_ready=1.
  - ACC0: first word transaction.
  - ACC1: second word transaction of a split access.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Accept: req_valid && req_ready at a rising edge. Register ea = req_base + sext(req_offset), size, sign, write flag and wdata.
- lane = ea[1:0]; mask = 1/3/F for B/H/W. Cross = (mask << lane) exceeds 4 bits.
- Error at accept → RESP with rsp_error=1. Error conditions:
  - funct3 in {3,6,7};
  - a store with funct3 4 or 5;
  - Cross with SPLIT_EN=0.
- Otherwise → ACC0.
- ACC0:
  - mem_req=1, mem_addr = {ea[ADDR_W-1:2], 2'b00}.
  - mem_be = (mask << lane)[3:0].
  - mem_wdata = wdata << 8*lane.
  - Hold all mem_* stable until mem_ack is seen high at a rising edge; capture mem_rdata into the low word of a 64-bit buffer.
  - Then go to ACC1 if Cross, else RESP.
- ACC1:
  - mem_addr = first address + 4, wrapping modulo 2^ADDR_W.
  - mem_be = (mask << lane)[7:4].
  - mem_wdata = wdata >> 8*(4-lane).
  - On mem_ack, capture mem_rdata into the high word, then go to RESP.
- mem_req deasserts in the cycle after the final ack. No back-to-back mem_req across transactions.
- Load result: raw = buffer >> 8*lane; take the low 8/16/32 bits, then sign-extend (funct3 0/1) or zero-extend (funct3 4/5).
- Latency from accept edge to rsp_valid, with zero-wait ack: aligned = 2 cycles, split = 3 cycles, error = 1 cycle. Each wait cycle on mem_ack adds one cycle.
- req_valid while not ready is ignored; the pipeline holds it. The response has no backpressure.
- mem_ack outside ACC0/ACC1 is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5;
  - the lsu_state_t enum {IDLE, ACC0, ACC1, RESP};
  - the size-to-mask function.
- One sub-module, lsu_align: purely combinational lane shifting, byte-enable generation and load extension. It is shared by the store and load paths and unit-testable on its own.
- The FSM and the registers stay in load_store_unit.

Test Plan:
- Load byte, signed: base=0x100, offset=0xFFF (−1), funct3=0, memory word @0xFC = 0x80_00_00_00, ack in the same cycle → mem_addr=0xFC, mem_be=4'b1000; rsp_rdata=0xFFFFFF80, 2 cycles after accept.
- Store halfword at lane 2: ea=0x22, wdata=0x1234ABCD, funct3=1 → mem_we=1, mem_addr=0x20, mem_be=4'b1100, mem_wdata=0xABCD0000; single transaction; rsp_error=0.
- Split load word: ea=0x43, words @0x40=0x44332211 and @0x44=0x88776655, funct3=2 → two transactions with mem_be=1000 then 0111; rsp_rdata=0x77665544, 3 cycles after accept.
- Illegal encodings: store with funct3=4, or load with funct3=7 → no mem_req; rsp_valid and rsp_error high 1 cycle after accept; rsp_rdata=0. With SPLIT_EN=0, a word load at ea=0x41 also errors.
- Wait states and wrap: ack delayed 3 cycles → mem_* stable throughout, latency +3. Load halfword, unsigned, at ea=0xFFFFFFFF → second transaction at mem_addr=0x00000000; result = {byte@0, byte@0xFFFFFFFF} zero-extended.
- Reset mid-ACC0: assert rst_n low while mem_req=1 → mem_req falls without waiting for a clock edge; after release, req_ready=1 and no rsp_valid ever appears.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access-size to byte-mask mapping.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // A zero mask marks an encoding with no defined access size.
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_mask = 4'h1;
      F3_H, F3_HU: size_mask = 4'h3;
      F3_W:        size_mask = 4'hF;
      default:     size_mask = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store data for both words of an
// access, word-crossing detection, and extraction/extension of load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] ld_buf_i,
  output logic [3:0]  be_lo_o,
  output logic [3:0]  be_hi_o,
  output logic [31:0] wdata_lo_o,
  output logic [31:0] wdata_hi_o,
  output logic        cross_o,
  output logic [31:0] ld_data_o
);

  logic [5:0]  sh;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] raw;

  assign sh      = {1'b0, lane_i, 3'b000};
  assign be_wide = {4'h0, size_mask(funct3_i)} << lane_i;
  assign wd_wide = {32'h0, wdata_i} << sh;

  assign be_lo_o    = be_wide[3:0];
  assign be_hi_o    = be_wide[7:4];
  assign cross_o    = |be_wide[7:4];
  assign wdata_lo_o = wd_wide[31:0];
  assign wdata_hi_o = wd_wide[63:32];

  // The two-word buffer holds the first word low, so one shift by the lane
  // lines up aligned and split loads alike.
  assign raw = ld_buf_i[sh +: 32];

  always_comb begin
    ld_data_o = '0;
    case (funct3_i)
      F3_B:    ld_data_o = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ld_data_o = {{16{raw[15]}}, raw[15:0]};
      F3_W:    ld_data_o = raw;
      F3_BU:   ld_data_o = {24'h0, raw[7:0]};
      F3_HU:   ld_data_o = {16'h0, raw[15:0]};
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store at a time, issues one or two
// word transactions, and returns a single-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit          SPLIT_EN = 1'b1,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [11:0]       req_offset,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_error,
  output logic [31:0]       rsp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output lsu_state_t        dbg_state_o
);

  // Handshakes: a request is taken on any rising edge with req_valid and
  // req_ready high; a memory transaction completes on any rising edge with
  // mem_req and mem_ack high; rsp_valid is a one-cycle pulse with no stall.

  lsu_state_t        state_q;
  logic              req_ready_q;
  logic              rsp_valid_q, rsp_error_q;
  logic [31:0]       rsp_rdata_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic [1:0]        lane_q;
  logic [2:0]        funct3_q;
  logic              write_q, cross_q;
  logic [31:0]       wdata_q, buf_lo_q;

  logic [ADDR_W-1:0] ea;
  logic              idle;
  logic [1:0]        sel_lane;
  logic [2:0]        sel_funct3;
  logic [31:0]       sel_wdata;
  logic [63:0]       ld_buf;
  logic [3:0]        a_be_lo, a_be_hi;
  logic [31:0]       a_wdata_lo, a_wdata_hi, a_ld_data, rsp_data;
  logic              a_cross, bad_enc, acc_err;

  assign ea   = req_base + {{(ADDR_W-12){req_offset[11]}}, req_offset};
  assign idle = (state_q == IDLE);

  // In IDLE the aligner looks at the incoming request so ACC0 can launch on
  // the accept edge; afterwards it works from the captured request.
  assign sel_lane   = idle ? ea[1:0]    : lane_q;
  assign sel_funct3 = idle ? req_funct3 : funct3_q;
  assign sel_wdata  = idle ? req_wdata  : wdata_q;
  assign ld_buf     = (state_q == ACC1) ? {mem_rdata, buf_lo_q} : {32'h0, mem_rdata};

  lsu_align u_align (
    .lane_i     (sel_lane),
    .funct3_i   (sel_funct3),
    .wdata_i    (sel_wdata),
    .ld_buf_i   (ld_buf),
    .be_lo_o    (a_be_lo),
    .be_hi_o    (a_be_hi),
    .wdata_lo_o (a_wdata_lo),
    .wdata_hi_o (a_wdata_hi),
    .cross_o    (a_cross),
    .ld_data_o  (a_ld_data)
  );

  assign bad_enc  = (size_mask(req_funct3) == 4'h0) ||
                    (req_write && (req_funct3 == F3_BU || req_funct3 == F3_HU));
  assign acc_err  = bad_enc || (a_cross && !SPLIT_EN);
  assign rsp_data = write_q ? 32'h0 : a_ld_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      lane_q      <= '0;
      funct3_q    <= '0;
      write_q     <= 1'b0;
      cross_q     <= 1'b0;
      wdata_q     <= '0;
      buf_lo_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            lane_q      <= ea[1:0];
            funct3_q    <= req_funct3;
            write_q     <= req_write;
            wdata_q     <= req_wdata;
            cross_q     <= a_cross;
            req_ready_q <= 1'b0;
            if (acc_err) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
            end else begin
              state_q     <= ACC0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_write;
              mem_addr_q  <= {ea[ADDR_W-1:2], 2'b00};
              mem_be_q    <= a_be_lo;
              mem_wdata_q <= a_wdata_lo;
            end
          end
        end
        ACC0: begin
          if (mem_ack) begin
            buf_lo_q <= mem_rdata;
            if (cross_q) begin
              state_q     <= ACC1;
              mem_addr_q  <= mem_addr_q + ADDR_W'(4);
              mem_be_q    <= a_be_hi;
              mem_wdata_q <= a_wdata_hi;
            end else begin
              state_q     <= RESP;
              mem_req_q   <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= '0;
              mem_be_q    <= '0;
              mem_wdata_q <= '0;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_data;
            end
          end
        end
        ACC1: begin
          if (mem_ack) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_data;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: memory responder with configurable
// ack delay, response scoreboard, and one task per scenario.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  lsu_state_t  dbg_state;

  logic        req_valid_ns, req_ready_ns, rsp_valid_ns, rsp_error_ns;
  logic [31:0] rsp_rdata_ns;
  logic        mem_req_ns, mem_we_ns;
  logic [31:0] mem_addr_ns, mem_wdata_ns;
  logic [3:0]  mem_be_ns;
  lsu_state_t  dbg_state_ns;
  logic        ns_mem_seen;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        txn_q[$];
  logic [32:0] exp_q[$];
  logic [31:0] mem_arr [256];
  int          ack_delay, wait_cnt;
  int          checks, failures;

  load_store_unit #(.SPLIT_EN(1'b1), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_base(req_base), .req_offset(req_offset), .req_funct3(req_funct3),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  load_store_unit #(.SPLIT_EN(1'b0), .ADDR_W(32)) dut_ns (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_ns), .req_ready(req_ready_ns), .req_write(req_write),
    .req_base(req_base), .req_offset(req_offset), .req_funct3(req_funct3),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_ns), .rsp_error(rsp_error_ns), .rsp_rdata(rsp_rdata_ns),
    .mem_req(mem_req_ns), .mem_we(mem_we_ns), .mem_addr(mem_addr_ns), .mem_be(mem_be_ns),
    .mem_wdata(mem_wdata_ns), .mem_ack(mem_req_ns), .mem_rdata(32'h0),
    .dbg_state_o(dbg_state_ns)
  );

  // ---------------- clock / reset / memory responder ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem_arr[mem_addr[9:2]];

  always @(negedge clk) begin
    if (mem_req && mem_ack) txn_q.push_back({mem_we, mem_be, mem_addr, mem_wdata});
    if (mem_req_ns) ns_mem_seen <= 1'b1;
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp: got err=%0b rdata=%h, required no response", rsp_error, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_error, rsp_rdata} !== e) begin
          failures++;
          $display("FAIL rsp_data: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   rsp_error, rsp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_arr[a[9:2]];
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] ea, input logic [2:0] f3);
    logic [31:0] v;
    int n;
    v = '0;
    n = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    for (int i = 0; i < n; i++) v[8*i +: 8] = byte_at(ea + 32'(i));
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input logic wr, input logic [31:0] base, input logic [11:0] off,
                        input logic [2:0] f3, input logic [31:0] wd, input logic [32:0] exp,
                        input bit chk_stable, output int lat);
    int   guard;
    bit   done, have_snap;
    txn_t snap;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_wait: got %0b, required 1", req_ready);
    end
    txn_q.delete();
    exp_q.push_back(exp);
    req_write = wr; req_base = base; req_offset = off; req_funct3 = f3; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; done = 0; have_snap = 0; snap = '0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) done = 1;
      else if (chk_stable && mem_req) begin
        checks++;
        if (req_ready !== 1'b0) begin
          failures++;
          $display("FAIL busy_ready: got %0b, required 0", req_ready);
        end
        if (!have_snap) begin
          snap = {mem_we, mem_be, mem_addr, mem_wdata};
          have_snap = 1;
        end else begin
          checks++;
          if ({mem_we, mem_be, mem_addr, mem_wdata} !== snap) begin
            failures++;
            $display("FAIL mem_stable: got %h, required %h", {mem_we, mem_be, mem_addr, mem_wdata}, snap);
          end
        end
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, lat);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rsp_pulse: rsp_valid=%0b a cycle later, required 0", rsp_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if ({req_ready, rsp_valid, rsp_error, mem_req, mem_we} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, required 10000", {req_ready, rsp_valid, rsp_error, mem_req, mem_we});
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_addr, mem_be, mem_wdata, rsp_rdata} !== 100'h0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h be=%h wd=%h rd=%h, required 0", mem_addr, mem_be, mem_wdata, rsp_rdata);
    end
    checks++;
    if (req_ready !== 1'b1 || req_ready_ns !== 1'b1 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_ready: got %0b/%0b state=%0d, required 1/1 state=0", req_ready, req_ready_ns, dbg_state);
    end
  endtask

  task automatic test_load_byte();
    int lat;
    mem_arr[8'h3F] = 32'h8000_0000;
    do_req(1'b0, 32'h100, 12'hFFF, 3'd0, 32'h0, {1'b0, 32'hFFFF_FF80}, 1'b0, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL lb_latency: got %0d, required 2", lat); end
    checks++;
    if (txn_q.size() !== 1) begin failures++; $display("FAIL lb_txn_count: got %0d, required 1", txn_q.size()); end
    else begin
      checks++;
      if (txn_q[0] !== {1'b0, 4'b1000, 32'hFC, 32'h0}) begin
        failures++; $display("FAIL lb_txn: got %h, required %h", txn_q[0], {1'b0, 4'b1000, 32'hFC, 32'h0});
      end
    end
  endtask

  task automatic test_store_half();
    int lat;
    do_req(1'b1, 32'h20, 12'h002, 3'd1, 32'h1234_ABCD, {1'b0, 32'h0}, 1'b0, lat);
    checks++;
    if (txn_q.size() !== 1) begin failures++; $display("FAIL sh_txn_count: got %0d, required 1", txn_q.size()); end
    else begin
      checks++;
      if (txn_q[0] !== {1'b1, 4'b1100, 32'h20, 32'hABCD_0000}) begin
        failures++; $display("FAIL sh_txn: got %h, required %h", txn_q[0], {1'b1, 4'b1100, 32'h20, 32'hABCD_0000});
      end
    end
  endtask

  task automatic test_split_load();
    int lat;
    mem_arr[8'h10] = 32'h4433_2211;
    mem_arr[8'h11] = 32'h8877_6655;
    do_req(1'b0, 32'h40, 12'h003, 3'd2, 32'h0, {1'b0, 32'h7766_5544}, 1'b0, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL lw_split_latency: got %0d, required 3", lat); end
    checks++;
    if (txn_q.size() !== 2) begin failures++; $display("FAIL lw_split_count: got %0d, required 2", txn_q.size()); end
    else begin
      checks++;
      if (txn_q[0] !== {1'b0, 4'b1000, 32'h40, 32'h0} || txn_q[1] !== {1'b0, 4'b0111, 32'h44, 32'h0}) begin
        failures++; $display("FAIL lw_split_txn: got %h / %h", txn_q[0], txn_q[1]);
      end
    end
  endtask

  task automatic test_split_store();
    int lat;
    do_req(1'b1, 32'h30, 12'h006, 3'd2, 32'hDDCC_BBAA, {1'b0, 32'h0}, 1'b0, lat);
    checks++;
    if (txn_q.size() !== 2) begin failures++; $display("FAIL sw_split_count: got %0d, required 2", txn_q.size()); end
    else begin
      checks++;
      if (txn_q[0] !== {1'b1, 4'b1100, 32'h34, 32'hBBAA_0000} || txn_q[1] !== {1'b1, 4'b0011, 32'h38, 32'h0000_DDCC}) begin
        failures++; $display("FAIL sw_split_txn: got %h / %h", txn_q[0], txn_q[1]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] tbl [3];
    int lat;
    tbl[0] = {1'b1, 3'd4};
    tbl[1] = {1'b0, 3'd7};
    tbl[2] = {1'b1, 3'd3};
    for (int i = 0; i < 3; i++) begin
      do_req(tbl[i][3], 32'h50, 12'h000, tbl[i][2:0], 32'hFFFF_FFFF, {1'b1, 32'h0}, 1'b0, lat);
      checks++;
      if (lat !== 1) begin failures++; $display("FAIL illegal_latency[%0d]: got %0d, required 1", i, lat); end
      checks++;
      if (txn_q.size() !== 0) begin failures++; $display("FAIL illegal_mem[%0d]: got %0d txns, required 0", i, txn_q.size()); end
    end
  endtask

  task automatic test_no_split();
    @(negedge clk);
    req_write = 1'b0; req_base = 32'h40; req_offset = 12'h001; req_funct3 = 3'd2; req_wdata = 32'h0;
    req_valid_ns = 1'b1;
    @(posedge clk);
    #1 req_valid_ns = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid_ns, rsp_error_ns, rsp_rdata_ns} !== {2'b11, 32'h0}) begin
      failures++;
      $display("FAIL nosplit_rsp: got v=%0b e=%0b rd=%h, required 1 1 0", rsp_valid_ns, rsp_error_ns, rsp_rdata_ns);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (ns_mem_seen !== 1'b0) begin failures++; $display("FAIL nosplit_mem: mem_req seen=%0b, required 0", ns_mem_seen); end
  endtask

  task automatic test_wait_states();
    int lat;
    mem_arr[8'h20] = 32'hCAFE_F00D;
    ack_delay = 3;
    do_req(1'b0, 32'h80, 12'h000, 3'd2, 32'h0, {1'b0, 32'hCAFE_F00D}, 1'b1, lat);
    ack_delay = 0;
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL wait_latency: got %0d, required 5", lat); end
  endtask

  task automatic test_wrap();
    int lat;
    mem_arr[8'hFF] = 32'hAB00_0000;
    mem_arr[8'h00] = 32'h0000_00CD;
    do_req(1'b0, 32'hFFFF_FFFF, 12'h000, 3'd5, 32'h0, {1'b0, 32'h0000_CDAB}, 1'b0, lat);
    checks++;
    if (txn_q.size() !== 2) begin failures++; $display("FAIL wrap_count: got %0d, required 2", txn_q.size()); end
    else begin
      checks++;
      if (txn_q[0].addr !== 32'hFFFF_FFFC || txn_q[1].addr !== 32'h0 || txn_q[1].be !== 4'b0001) begin
        failures++; $display("FAIL wrap_txn: got %h / %h", txn_q[0], txn_q[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3_tbl [5];
    logic [31:0] base;
    logic [11:0] off;
    logic [2:0]  f3;
    int lat;
    f3_tbl[0] = 3'd0; f3_tbl[1] = 3'd1; f3_tbl[2] = 3'd2; f3_tbl[3] = 3'd4; f3_tbl[4] = 3'd5;
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    for (int n = 0; n < 24; n++) begin
      base = $urandom;
      off  = 12'($urandom_range(0, 4095));
      f3   = f3_tbl[$urandom_range(0, 4)];
      ack_delay = $urandom_range(0, 2);
      do_req(1'b0, base, off, f3, 32'h0,
             {1'b0, model_load(base + {{20{off[11]}}, off}, f3)}, 1'b0, lat);
    end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid();
    ack_delay = 20;
    @(negedge clk);
    req_write = 1'b0; req_base = 32'h80; req_offset = 12'h0; req_funct3 = 3'd2; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_req: got %0b, required 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_async: mem_req=%0b, required 0", mem_req); end
    @(negedge clk) rst_n = 1'b1;
    ack_delay = 0;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_rsp: rsp_valid=%0b, required 0", rsp_valid); end
    end
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %0b, required 1", req_ready); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    checks = 0; failures = 0; ack_delay = 0; ns_mem_seen = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; req_valid_ns = 1'b0; req_write = 1'b0;
    req_base = '0; req_offset = '0; req_funct3 = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_load_byte();
    test_store_half();
    test_split_load();
    test_split_store();
    test_illegal();
    test_no_split();
    test_wait_states();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_left: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
